// File: rtl/uart_lite_pkg.sv
// Shared definitions for the UART lite receive path: controller state
// encoding and the defaults the receive blocks derive their parameters from.
package uart_lite_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_BREAK  = 2'd3
    } rx_state_e;

    localparam int DEF_OVERSAMPLING = 16;
    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_FIFO_DEPTH   = 4;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rx_controller_if.sv
// Signal bundle between the receive controller (master) and its surroundings:
// the character_recovery core on one side and the host register block on the other.
interface uart_rx_controller_if import uart_lite_pkg::*; #(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

    logic                 en_i;
    logic                 rx_i;
    logic [DATA_BITS-1:0] rec_char_i;
    logic                 rec_valid_i;
    logic                 rec_rst_o;
    logic [DATA_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [LEVEL_W-1:0]   level_o;
    logic                 overrun_o;
    logic                 overrun_clr_i;
    logic                 break_o;

    modport master (
        input  en_i, rx_i, rec_char_i, rec_valid_i, ready_i, overrun_clr_i,
        output rec_rst_o, data_o, valid_o, level_o, overrun_o, break_o
    );

    modport slave (
        output en_i, rx_i, rec_char_i, rec_valid_i, ready_i, overrun_clr_i,
        input  rec_rst_o, data_o, valid_o, level_o, overrun_o, break_o
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received characters; a push into a full FIFO
// is accepted only when a pop frees a slot on the same edge.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rstN,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [LVL_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == LVL_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_level  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    // Storage is cleared on reset so the head reads zero before the first push.
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count <= r_count + LVL_W'(w_doPush) - LVL_W'(w_doPop);
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// Receive-side controller: sequences the character_recovery core through
// off/settle/run/break phases and buffers recovered characters for the host.
module uart_rx_controller import uart_lite_pkg::*; #(
    parameter int OVERSAMPLING = DEF_OVERSAMPLING,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int IDLE_CYCLES  = OVERSAMPLING,
    parameter int BREAK_CYCLES = OVERSAMPLING * (DATA_BITS + 2)
) (
    input  logic clk_i,
    input  logic rst_ni,
    uart_rx_controller_if.master bus
);
    localparam int                CNT_W     = $clog2(maxOf(IDLE_CYCLES, BREAK_CYCLES) + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  IDLE_CNT  = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0]  BREAK_CNT = CNT_W'(BREAK_CYCLES);

    rx_state_e        r_state;
    rx_state_e        w_nextState;
    logic [CNT_W-1:0] r_runCnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic [CNT_W-1:0] w_cntInc;
    logic             r_overrun;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;

    assign w_cntInc = (r_runCnt == CNT_MAX) ? r_runCnt : r_runCnt + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_OFF;
            r_runCnt <= '0;
        end else begin
            r_state  <= w_nextState;
            r_runCnt <= w_nextCnt;
        end
    end

    // One counter serves both phases: high-run length in SETTLE, low-run length in RUN.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_runCnt;
        if (!bus.en_i) begin
            w_nextState = ST_OFF;
            w_nextCnt   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_nextState = ST_SETTLE;
                    w_nextCnt   = '0;
                end
                ST_SETTLE: begin
                    if (!bus.rx_i) begin
                        w_nextCnt = '0;
                    end else if (w_cntInc == IDLE_CNT) begin
                        w_nextState = ST_RUN;
                        w_nextCnt   = '0;
                    end else begin
                        w_nextCnt = w_cntInc;
                    end
                end
                ST_RUN: begin
                    if (bus.rx_i) begin
                        w_nextCnt = '0;
                    end else if (w_cntInc == BREAK_CNT) begin
                        w_nextState = ST_BREAK;
                        w_nextCnt   = '0;
                    end else begin
                        w_nextCnt = w_cntInc;
                    end
                end
                ST_BREAK: begin
                    // The sample that ends the break already counts towards settling.
                    if (bus.rx_i) begin
                        w_nextState = ST_SETTLE;
                        w_nextCnt   = CNT_W'(1);
                    end
                end
                default: begin
                    w_nextState = ST_OFF;
                    w_nextCnt   = '0;
                end
            endcase
        end
    end

    assign bus.rec_rst_o = (r_state != ST_RUN);
    assign bus.break_o   = (r_state == ST_BREAK);

    assign w_push      = bus.rec_valid_i && (r_state == ST_RUN);
    assign w_pop       = bus.ready_i && !w_empty;
    assign w_drop      = w_push && w_full && !w_pop;
    assign bus.valid_o = !w_empty;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rstN  (rst_ni),
        .i_push  (w_push),
        .i_data  (bus.rec_char_i),
        .i_pop   (w_pop),
        .o_data  (bus.data_o),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (bus.level_o)
    );

    // A drop on the same edge as a clear request leaves the flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (bus.overrun_clr_i) begin
            r_overrun <= 1'b0;
        end
    end

    assign bus.overrun_o = r_overrun;

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Receive-side controller for the UART lite: sequences the `character_recovery` core through disable, line-settle, run and break phases by driving its synchronous active-high reset. Accepts recovered characters into a small FIFO presented to the host with a valid/ready handshake. Flags overrun and line-break conditions. Sits between `character_recovery` and the bus-facing register block.

## Interface

Parameters:
- `OVERSAMPLING`, default 16: samples per bit; used only for default derivations.
- `DATA_BITS`, default 8: character width.
- `FIFO_DEPTH`, default 4: characters buffered; must be a power of two, ≥2.
- `IDLE_CYCLES`, default `OVERSAMPLING`: consecutive high rx samples required before the core is released.
- `BREAK_CYCLES`, default `OVERSAMPLING*(DATA_BITS+2)`: consecutive low rx samples that constitute a break.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `en_i`, in, 1: receiver enable.
- `rx_i`, in, 1: synchronised rx line, the same signal fed to the core.
- `rec_char_i`, in, `DATA_BITS`: core `char_o`.
- `rec_valid_i`, in, 1: core `valid_o`.
- `rec_rst_o`, out, 1: core `rst_i`, registered.
- `data_o`, out, `DATA_BITS`: FIFO head.
- `valid_o`, out, 1: FIFO non-empty.
- `ready_i`, in, 1: host pops head when `valid_o & ready_i`.
- `level_o`, out, `$clog2(FIFO_DEPTH+1)`: occupancy.
- `overrun_o`, out, 1: sticky; a character was dropped.
- `overrun_clr_i`, in, 1: clears `overrun_o`.
- `break_o`, out, 1: high while in BREAK.

## Operation

The block is built around a four-state FSM:
- **OFF**: `rec_rst_o`=1. Moves to SETTLE when `en_i`=1.
- **SETTLE**: `rec_rst_o`=1.
  - `run_cnt` counts consecutive high `rx_i` samples; a low sample zeroes it.
  - On the edge where the count reaches `IDLE_CYCLES`, go to RUN and zero `run_cnt`.
- **RUN**: `rec_rst_o`=0.
  - `run_cnt` counts consecutive low samples; a high sample zeroes it.
  - On the edge where the count reaches `BREAK_CYCLES`, go to BREAK.
- **BREAK**: `rec_rst_o`=1, `break_o`=1. The first high `rx_i` sample moves to SETTLE with `run_cnt`=1.

Global rules:
- `en_i`=0 in any state moves to OFF on the next edge; this has priority over all other transitions.
- `run_cnt` is one shared counter, width `$clog2(max(IDLE_CYCLES,BREAK_CYCLES)+1)`. It saturates and is zeroed on every state change except BREAK→SETTLE.
- `rec_rst_o` and `break_o` are decodes of the registered state.

FIFO push and pop:
- Push occurs when `rec_valid_i`=1 and state is RUN.
- If the FIFO is full and no pop happens in the same cycle, the character is dropped and `overrun_o` sets.
- Full with simultaneous push and pop: both occur and `overrun_o` is unchanged.
- Empty with a push: `valid_o` rises the next cycle; there is no fall-through.
- If `overrun_o` sets in the same cycle as `overrun_clr_i`, the set wins.
- Disabling, BREAK and SETTLE do not flush the FIFO; the host may drain it in any state.

Reset values:
- State OFF, `rec_rst_o`=1, `run_cnt`=0.
- FIFO empty: `valid_o`=0, `level_o`=0, `data_o`=0.
- `overrun_o`=0, `break_o`=0.

## Timing

Enable and settle:
- `en_i` is sampled high at edge E0, giving SETTLE after E0.
- With `rx_i` high at E1..E`IDLE_CYCLES`, `rec_rst_o` falls after edge E`IDLE_CYCLES`.

Data path:
- A `rec_valid_i` pulse at edge N updates `valid_o`, `data_o` and `level_o` after edge N.
- A pop at edge N decrements `level_o` and advances `data_o` after edge N.

Break:
- `rx_i` low for `BREAK_CYCLES` samples in RUN raises `break_o` and `rec_rst_o` after the final sample's edge.
- Any `rec_valid_i` on that same edge is still accepted, because the state was RUN.

Disable and host handshake:
- `en_i` low at edge N raises `rec_rst_o` after N.
- The host may hold `ready_i` high continuously.
- `data_o` is stable while `valid_o & !ready_i`.

## Structure

- Shared package `uart_lite_pkg`: state encoding (OFF/SETTLE/RUN/BREAK) and default-derivation constants.
- Sub-module `uart_rx_fifo`: synchronous FIFO with push, pop, full, empty and level, plus the full-push-with-pop rule.
- The FSM, `run_cnt` and overrun flag live in the top module.

## Test plan

1. **Reset and enable.** Reset, then `en_i`=1 with `rx_i` high -> `rec_rst_o`=1 for 16 cycles after enable, then 0; all other outputs at reset values.
2. **Single character.** RUN, `rec_valid_i` pulse with `rec_char_i`=0xA5, `ready_i`=0 -> next cycle `valid_o`=1, `data_o`=0xA5, `level_o`=1; assert `ready_i` -> `level_o`=0.
3. **Overrun.** Push 0x01..0x04 with no pops, then push 0x05 -> `level_o`=4, `overrun_o`=1, head 0x01. Push 0x06 together with a pop -> `level_o` stays 4, tail 0x06. Pulse `overrun_clr_i` -> `overrun_o`=0.
4. **Break.** RUN, `rx_i` low for 159 cycles then high -> no BREAK. Low for 160 cycles -> `break_o`=1, `rec_rst_o`=1. Then `rx_i` high for 16 cycles -> RUN.
5. **Settle glitch.** In SETTLE, `rx_i` high 10 cycles, low 1 cycle, then high -> RUN is reached only after 16 further high samples.
6. **Mid-operation disable and async reset.** `en_i`=0 with 2 characters queued -> OFF, FIFO still drains 2. Assert `rst_ni` mid-character -> outputs reset immediately, without waiting for a clock edge.
